// File: rtl/hw_qsys_i2c_sda_in_pkg.sv
// ---------------------------------------------------------------------------
// hw_qsys_pio_pkg
// Shared constants for the Qsys I2C line-readback input port: register
// addresses, edge-select encodings and the filter counter width helper.
// No ports (package).
// ---------------------------------------------------------------------------
package hw_qsys_pio_pkg;

  // Avalon-MM register addresses
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Edge-select encodings for the capture register
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Bits needed to hold 0..filter_cycles, i.e. clog2(filter_cycles + 1),
  // never less than one bit.
  function automatic int cnt_width(input int filter_cycles);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << i) < (filter_cycles + 1)) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/hw_qsys_i2c_sda_in_glitch_filter.sv
// ---------------------------------------------------------------------------
// hw_qsys_glitch_filter
// Single-bit two-flop synchroniser followed by a stable-sample glitch filter.
// The filtered output only follows the synchronised pin after it has held a
// new value for FILTER_CYCLES consecutive samples.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   i_pin      in   asynchronous pin input
//   o_filtered out  registered, filtered pin value
// ---------------------------------------------------------------------------
module hw_qsys_glitch_filter
  import hw_qsys_pio_pkg::*;
#(
  parameter int   FILTER_CYCLES = 3,
  parameter logic RESET_BIT     = 1'b1,
  parameter int   CNT_W         = cnt_width(FILTER_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_filtered
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_sync0;
  logic             r_sync1;
  logic             r_filtered;
  logic [CNT_W-1:0] r_cnt;

  // Synchronise the pin and count consecutive samples that disagree with
  // the filtered value; the count restarts on any agreeing sample, so a
  // pulse shorter than FILTER_CYCLES samples never reaches r_filtered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync0    <= RESET_BIT;
      r_sync1    <= RESET_BIT;
      r_filtered <= RESET_BIT;
      r_cnt      <= CNT_ZERO;
    end else begin
      r_sync0 <= i_pin;
      r_sync1 <= r_sync0;
      if (r_sync1 == r_filtered) begin
        r_cnt <= CNT_ZERO;
      end else if (r_cnt == CNT_LAST) begin
        r_filtered <= r_sync1;
        r_cnt      <= CNT_ZERO;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign o_filtered = r_filtered;

endmodule

// File: rtl/hw_qsys_i2c_sda_in.sv
// ---------------------------------------------------------------------------
// hw_qsys_i2c_sda_in
// Avalon-MM input PIO for bit-banged I2C line readback. Each pin is
// synchronised and glitch filtered; filtered edges set write-1-to-clear
// capture bits that drive a maskable level interrupt.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous active-high reset
//   address     in   register select (0 data, 1 reserved, 2 mask, 3 edge)
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   write data
//   in_port     in   asynchronous pin inputs
//   readdata    out  registered read data, latency 1
//   irq         out  level interrupt, |(edge_capture & irq_mask)
// ---------------------------------------------------------------------------
module hw_qsys_i2c_sda_in
  import hw_qsys_pio_pkg::*;
#(
  parameter int DATA_WIDTH    = 1,
  parameter int FILTER_CYCLES = 3,
  parameter int EDGE_TYPE     = 1,
  parameter int RESET_VALUE   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam logic                  RST_BIT = (RESET_VALUE != 0);
  localparam logic [DATA_WIDTH-1:0] RST_VEC = {DATA_WIDTH{RST_BIT}};
  localparam logic [DATA_WIDTH-1:0] ZERO_V  = {DATA_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] w_filtered;
  logic [DATA_WIDTH-1:0] w_edge_det;
  logic [DATA_WIDTH-1:0] w_clr;
  logic [31:0]           w_rd_mux;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_unused_wdata;

  logic [DATA_WIDTH-1:0] r_filtered_d;
  logic [DATA_WIDTH-1:0] r_edge_capture;
  logic [DATA_WIDTH-1:0] r_irq_mask;
  logic [31:0]           r_readdata;

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_bit
    hw_qsys_glitch_filter #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .RESET_BIT     (RST_BIT)
    ) u_filt (
      .clk        (clk),
      .reset      (reset),
      .i_pin      (in_port[g]),
      .o_filtered (w_filtered[g])
    );
  end

  assign w_rd = chipselect & write_n;
  assign w_wr = chipselect & ~write_n;

  // Upper writedata bits are only meaningful when DATA_WIDTH is 32.
  assign w_unused_wdata = ^writedata;

  // Select which filtered transitions set capture bits.
  always_comb begin
    w_edge_det = ZERO_V;
    case (EDGE_TYPE)
      EDGE_RISING:  w_edge_det = w_filtered & ~r_filtered_d;
      EDGE_FALLING: w_edge_det = ~w_filtered & r_filtered_d;
      EDGE_ANY:     w_edge_det = w_filtered ^ r_filtered_d;
      default:      w_edge_det = ~w_filtered & r_filtered_d;
    endcase
  end

  // Bits cleared by a write-1-to-clear access to the capture register.
  always_comb begin
    if (w_wr && (address == ADDR_EDGE)) begin
      w_clr = writedata[DATA_WIDTH-1:0];
    end else begin
      w_clr = ZERO_V;
    end
  end

  // Read mux; unused and reserved addresses read as zero.
  always_comb begin
    w_rd_mux = 32'd0;
    case (address)
      ADDR_DATA: w_rd_mux = 32'(w_filtered);
      ADDR_RSVD: w_rd_mux = 32'd0;
      ADDR_MASK: w_rd_mux = 32'(r_irq_mask);
      ADDR_EDGE: w_rd_mux = 32'(r_edge_capture);
      default:   w_rd_mux = 32'd0;
    endcase
  end

  // Edge history, capture/mask registers and latency-1 read data. The set
  // term is OR-ed after the clear so a coincident edge always survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filtered_d   <= RST_VEC;
      r_edge_capture <= ZERO_V;
      r_irq_mask     <= ZERO_V;
      r_readdata     <= 32'd0;
    end else begin
      r_filtered_d   <= w_filtered;
      r_edge_capture <= (r_edge_capture & ~w_clr) | w_edge_det;
      if (w_wr && (address == ADDR_MASK)) begin
        r_irq_mask <= writedata[DATA_WIDTH-1:0];
      end
      if (w_rd) begin
        r_readdata <= w_rd_mux;
      end
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edge_capture & r_irq_mask);

endmodule

// File: tb/tb_hw_qsys_i2c_sda_in.sv
module tb_hw_qsys_i2c_sda_in;

  localparam int DW    = 2;
  localparam int FC    = 3;
  localparam int EDGE  = 1;
  localparam logic [DW-1:0] RV_VEC = 2'b11;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [DW-1:0] in_port;
  logic [31:0]   readdata;
  logic          irq;

  int checks   = 0;
  int failures = 0;

  hw_qsys_i2c_sda_in #(
    .DATA_WIDTH    (DW),
    .FILTER_CYCLES (FC),
    .EDGE_TYPE     (EDGE),
    .RESET_VALUE   (1)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pins reach the filter input two samples late; the filtered value flips
  // once the last FC filter-input samples all disagree with it.
  logic [DW-1:0] pin_q[$];
  logic [DW-1:0] win_q[$];
  logic [31:0]   exp_q[$];
  logic [DW-1:0] m_filt, m_filt_d, m_cap, m_mask;
  logic          m_rd_pend = 1'b0;
  logic          m_started = 1'b0;
  logic          m_irq;

  assign m_irq = |(m_cap & m_mask);

  function automatic logic [DW-1:0] filt_next(input logic [DW-1:0] cur);
    logic [DW-1:0] nxt;
    bit all_diff;
    nxt = cur;
    if (win_q.size() == FC) begin
      for (int b = 0; b < DW; b++) begin
        all_diff = 1'b1;
        foreach (win_q[i]) if (win_q[i][b] == cur[b]) all_diff = 1'b0;
        if (all_diff) nxt[b] = ~cur[b];
      end
    end
    return nxt;
  endfunction

  function automatic logic [DW-1:0] edge_bits(input logic [DW-1:0] f, input logic [DW-1:0] fd);
    case (EDGE)
      0:       return f & ~fd;
      1:       return ~f & fd;
      default: return f ^ fd;
    endcase
  endfunction

  function automatic logic [31:0] reg_view(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_filt);
      2'd2:    return 32'(m_mask);
      2'd3:    return 32'(m_cap);
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      pin_q.delete();
      pin_q.push_back(RV_VEC);
      pin_q.push_back(RV_VEC);
      win_q.delete();
      m_filt    <= RV_VEC;
      m_filt_d  <= RV_VEC;
      m_cap     <= '0;
      m_mask    <= '0;
      m_rd_pend <= 1'b0;
      m_started <= 1'b1;
    end else if (m_started) begin
      if (chipselect && write_n) exp_q.push_back(reg_view(address));
      m_rd_pend <= chipselect && write_n;
      m_cap <= (m_cap & ~((chipselect && !write_n && address == 2'd3) ? writedata[DW-1:0] : 2'b00))
               | edge_bits(m_filt, m_filt_d);
      if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[DW-1:0];
      win_q.push_back(pin_q.pop_front());
      pin_q.push_back(in_port);
      if (win_q.size() > FC) void'(win_q.pop_front());
      m_filt_d <= m_filt;
      m_filt   <= filt_next(m_filt);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (m_started) begin
      if (m_rd_pend) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_underflow actual=read_seen required=queued_expectation");
        end else begin
          check("readdata", readdata, exp_q.pop_front());
        end
      end
      check("irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int  got;
    bit  seen;
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
    writedata = 32'd0; in_port = 2'b00;

    // 1: reset with pins low; filtered stays high until filtered through
    idle(3);
    reset = 1'b0;
    check("reset_readdata", readdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    bus_read(2'd0);
    check("reset_data", readdata, 32'h3);
    for (int i = 0; i < 7; i++) bus_read(2'd0);
    in_port = 2'b11;
    idle(10);
    bus_write(2'd3, 32'h3);

    // 2: 2-cycle glitch discarded, 3-cycle pulse passes
    in_port[0] = 1'b0; idle(2); in_port[0] = 1'b1;
    idle(8);
    bus_read(2'd0);
    check("glitch_data", readdata, 32'h3);
    bus_read(2'd3);
    check("glitch_cap", readdata, 32'h0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_port[0] = (i < 3) ? 1'b0 : 1'b1;
      chipselect = 1'b1; write_n = 1'b1; address = 2'd0;
    end
    chipselect = 1'b0;
    idle(4);
    bus_write(2'd3, 32'h3);

    // 3: falling edge interrupt latency
    bus_write(2'd2, 32'h1);
    in_port[0] = 1'b0;
    got = 0; seen = 1'b0;
    for (int n = 1; n <= 12 && !seen; n++) begin
      @(posedge clk); #1;
      if (irq) begin got = n; seen = 1'b1; end
    end
    check("irq_latency", got, 32'd6);
    bus_read(2'd3);
    check("fall_cap", readdata, 32'h1);

    // 4: write-1-to-clear
    bus_write(2'd3, 32'h0);
    bus_read(2'd3);
    check("w1c_zero", readdata, 32'h1);
    bus_write(2'd3, 32'h1);
    check("w1c_irq", {31'd0, irq}, 32'd0);

    // 5: clear collides with a new falling edge
    in_port = 2'b11;
    idle(10);
    bus_write(2'd3, 32'h3);
    bus_write(2'd2, 32'h3);
    in_port[1] = 1'b0;
    idle(8);
    check("pre_collision_irq", {31'd0, irq}, 32'd1);
    in_port[0] = 1'b0;
    idle(4);
    bus_write(2'd3, 32'h3);
    check("collision_irq", {31'd0, irq}, 32'd1);
    bus_read(2'd3);
    check("collision_cap", readdata, 32'h1);

    // 6: reset in the middle of filtering
    in_port = 2'b11;
    idle(10);
    bus_write(2'd3, 32'h3);
    in_port = 2'b00;
    idle(4);
    reset = 1'b1; in_port = 2'b11;
    idle(2);
    reset = 1'b0;
    bus_read(2'd0);
    check("rst_mid_data", readdata, 32'h3);
    bus_read(2'd3);
    check("rst_mid_cap", readdata, 32'h0);
    check("rst_mid_irq", {31'd0, irq}, 32'd0);

    // 7: randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      int r;
      @(negedge clk);
      for (int b = 0; b < DW; b++) if ($urandom_range(0, 5) == 0) in_port[b] = ~in_port[b];
      reset = ($urandom_range(0, 249) == 0);
      r = $urandom_range(0, 9);
      address = 2'($urandom_range(0, 3));
      writedata = $urandom;
      if (r < 4) begin
        chipselect = 1'b0; write_n = 1'b1;
      end else if (r < 7) begin
        chipselect = 1'b1; write_n = 1'b1;
      end else begin
        chipselect = 1'b1; write_n = 1'b0;
      end
    end
    @(negedge clk);
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
